// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl
// Sequencer for the 8-lane column-MAC matrix-vector datapath. A start pulse
// walks the operand memory (one column + one vector element per cycle), feeds
// the registered operands to the datapath with en/valid, waits for the
// datapath result, captures it and offers it on a valid/ready handshake.
//
// Ports
//   clk_i, rstn_i        clock; synchronous active-high reset (1 = reset)
//   start_i              start pulse, honoured only while idle
//   busy_o, err_o        not-idle flag; sticky drain-timeout flag
//   mem_rd_o, mem_addr_o operand read strobe and column index k
//   mem_col_i, mem_x_i   column k / x[k], sampled at the edge that closes
//                        the mem_rd_o cycle for address k
//   mm_en_o, mm_valid_o  datapath enable / operand valid
//   mm_temp_o, mm_din3_o registered column / vector element to the datapath
//   mm_valid_i           datapath result valid (only looked at while draining)
//   mm_matmul_i          packed datapath result, lane j at [ACCW*j +: ACCW]
//   res_valid_o/ready_i  result handshake
//   res_data_o           captured result, stable while res_valid_o=1
//
// Every output is a flop, so reset drives a registered 0 onto all of them.

module matmul_seq_ctrl #(
  parameter int N       = 8,
  parameter int DW      = 8,
  parameter int ACCW    = 32,
  parameter int AW      = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              err_o,
  output logic              mem_rd_o,
  output logic [AW-1:0]     mem_addr_o,
  input  logic [N*DW-1:0]   mem_col_i,
  input  logic [DW-1:0]     mem_x_i,
  output logic              mm_en_o,
  output logic              mm_valid_o,
  output logic [N*DW-1:0]   mm_temp_o,
  output logic [DW-1:0]     mm_din3_o,
  input  logic              mm_valid_i,
  input  logic [N*ACCW-1:0] mm_matmul_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [N*ACCW-1:0] res_data_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     k_q, k_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mm_en_q, mm_en_d;
  logic              mm_valid_q, mm_valid_d;
  logic [N*DW-1:0]   mm_temp_q, mm_temp_d;
  logic [DW-1:0]     mm_din3_q, mm_din3_d;
  logic              res_valid_q, res_valid_d;
  logic [N*ACCW-1:0] res_data_q, res_data_d;

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered, so each registered output lines up with its state.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_rd_d    = 1'b0;
    mm_en_d     = mm_en_q;
    mm_valid_d  = 1'b0;
    mm_temp_d   = mm_temp_q;
    mm_din3_d   = mm_din3_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_READ;
          err_d    = 1'b0;
          k_d      = '0;
          mem_rd_d = 1'b1;
          mm_en_d  = 1'b1;
        end
      end

      // Each READ cycle closes by capturing the operand for address k, so
      // mm_valid_o trails mem_rd_o by exactly one cycle.
      S_READ: begin
        mm_temp_d  = mem_col_i;
        mm_din3_d  = mem_x_i;
        mm_valid_d = 1'b1;
        if (k_q == AW'(N - 1)) begin
          state_d = S_FEED;
          k_d     = '0;
        end else begin
          k_d      = k_q + 1'b1;
          mem_rd_d = 1'b1;
        end
      end

      // One extra cycle so the last operand gets its valid beat.
      S_FEED: begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end

      S_DRAIN: begin
        if (mm_valid_i) begin
          res_data_d  = mm_matmul_i;
          res_valid_d = 1'b1;
          mm_en_d     = 1'b0;
          state_d     = S_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) begin
            err_d   = 1'b1;
            mm_en_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      // start_i is deliberately not looked at here, even on the handshake
      // cycle; the next operation can only begin from IDLE.
      S_OUT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mm_en_q     <= 1'b0;
      mm_valid_q  <= 1'b0;
      mm_temp_q   <= '0;
      mm_din3_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      mem_rd_q    <= mem_rd_d;
      mm_en_q     <= mm_en_d;
      mm_valid_q  <= mm_valid_d;
      mm_temp_q   <= mm_temp_d;
      mm_din3_q   <= mm_din3_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = k_q;
  assign mm_en_o     = mm_en_q;
  assign mm_valid_o  = mm_valid_q;
  assign mm_temp_o   = mm_temp_q;
  assign mm_din3_o   = mm_din3_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl. A behavioural datapath (signed column
// MAC with a short result latency) and a combinational operand memory sit
// around the DUT. A timeline model (cycles since start acceptance) predicts
// every output each cycle; literal lane values pin the arithmetic.

module tb_matmul_seq_ctrl;
  localparam int N       = 8;
  localparam int DW      = 8;
  localparam int ACCW    = 32;
  localparam int AW      = 3;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rstn_i, start_i, res_ready_i;
  logic              busy_o, err_o, mem_rd_o, mm_en_o, mm_valid_o, res_valid_o;
  logic [AW-1:0]     mem_addr_o;
  logic [N*DW-1:0]   mem_col_i, mm_temp_o;
  logic [DW-1:0]     mem_x_i, mm_din3_o;
  logic              mm_valid_i;
  logic [N*ACCW-1:0] mm_matmul_i, res_data_o;

  matmul_seq_ctrl #(.N(N), .DW(DW), .ACCW(ACCW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .busy_o(busy_o), .err_o(err_o),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_col_i(mem_col_i), .mem_x_i(mem_x_i),
    .mm_en_o(mm_en_o), .mm_valid_o(mm_valid_o), .mm_temp_o(mm_temp_o), .mm_din3_o(mm_din3_o),
    .mm_valid_i(mm_valid_i), .mm_matmul_i(mm_matmul_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- operand memory ----------------
  logic [N*DW-1:0] mem_col [N];
  logic [DW-1:0]   mem_x   [N];
  assign mem_col_i = mem_col[mem_addr_o];
  assign mem_x_i   = mem_x[mem_addr_o];

  task automatic load_mem(input bit ramp, input logic [DW-1:0] cb, input logic [DW-1:0] xv);
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) mem_col[k][j*DW +: DW] = ramp ? DW'(k + 1) : cb;
      mem_x[k] = xv;
    end
  endtask

  function automatic logic [N*ACCW-1:0] calc_res();
    logic [N*ACCW-1:0] r;
    for (int j = 0; j < N; j++) begin
      int s;
      s = 0;
      for (int k = 0; k < N; k++)
        s += int'($signed(mem_col[k][j*DW +: DW])) * int'($signed(mem_x[k]));
      r[j*ACCW +: ACCW] = ACCW'(s);
    end
    return r;
  endfunction

  // ---------------- behavioural datapath ----------------
  bit   dp_never = 1'b0;
  bit   spur     = 1'b0;
  logic dp_vld;
  int   dp_cnt, dp_dly;
  logic signed [ACCW-1:0] acc [N];
  logic [N*ACCW-1:0] dp_pk;

  always @(posedge clk) begin
    if (rstn_i) begin
      dp_vld <= 1'b0;
      dp_cnt <= 0;
      dp_dly <= 0;
    end else begin
      dp_vld <= 1'b0;
      if (mm_en_o && mm_valid_o) begin
        for (int j = 0; j < N; j++) begin
          int p;
          p = int'($signed(mm_temp_o[j*DW +: DW])) * int'($signed(mm_din3_o));
          acc[j] <= ((dp_cnt == 0) ? 32'sd0 : acc[j]) + p;
        end
        dp_cnt <= (dp_cnt == N - 1) ? 0 : dp_cnt + 1;
        if (dp_cnt == N - 1 && !dp_never) dp_dly <= 2;
      end
      if (dp_dly > 0) begin
        dp_dly <= dp_dly - 1;
        if (dp_dly == 1) dp_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    dp_pk = '0;
    for (int j = 0; j < N; j++) dp_pk[j*ACCW +: ACCW] = acc[j];
  end

  assign mm_valid_i  = dp_vld | spur;
  assign mm_matmul_i = spur ? {N{32'hBAD0BAD0}} : (dp_vld ? dp_pk : '0);

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [N*ACCW-1:0] act, input logic [N*ACCW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_lanes(input string nm, input logic [N*ACCW-1:0] d, input int v);
    bit ok;
    ok = 1'b1;
    for (int j = 0; j < N; j++) if (d[j*ACCW +: ACCW] !== ACCW'(v)) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h want every lane %0d", nm, d, v);
    end
  endtask

  // ---------------- timeline model + per-cycle compare ----------------
  // m_s counts cycles since the start-accept edge (first READ cycle = 1).
  bit m_init = 0, m_active = 0, m_rv = 0, m_err = 0, m_rst_seen = 0;
  int m_s = 0;
  logic [N*ACCW-1:0] m_res;
  int v_cnt = 0;
  int last_v_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        bit e_rd, e_v;
        e_rd = m_active && m_s >= 1 && m_s <= N;
        e_v  = m_active && m_s >= 2 && m_s <= N + 1;
        chk("busy", busy_o, m_active);
        chk("err", err_o, m_err);
        chk("mem_rd", mem_rd_o, e_rd);
        chk("mm_valid", mm_valid_o, e_v);
        chk("mm_en", mm_en_o, m_active && !m_rv);
        chk("res_valid", res_valid_o, m_rv);
        if (e_rd) chk("mem_addr", mem_addr_o, m_s - 1);
        if (e_v) begin
          chk("mm_temp", mm_temp_o, mem_col[m_s-2]);
          chk("mm_din3", mm_din3_o, mem_x[m_s-2]);
        end
        if (m_rv) chk("res_data", res_data_o, m_res);
        if (m_rst_seen) begin
          chk("rst_addr", mem_addr_o, 0);
          chk("rst_temp", mm_temp_o, 0);
          chk("rst_din3", mm_din3_o, 0);
          chk("rst_data", res_data_o, 0);
        end
        if (mm_valid_o) begin
          v_cnt++;
          last_v_cyc = cyc;
        end
      end
      // advance the model to the next cycle using the inputs the DUT will see
      if (rstn_i) begin
        m_init = 1; m_active = 0; m_rv = 0; m_err = 0; m_s = 0; m_rst_seen = 1;
      end else begin
        m_rst_seen = 0;
        if (!m_active) begin
          if (start_i) begin m_active = 1; m_s = 1; m_err = 0; end
        end else if (m_rv) begin
          if (res_ready_i) begin m_active = 0; m_rv = 0; end
        end else if (m_s >= N + 2) begin
          if (mm_valid_i) begin m_rv = 1; m_res = calc_res(); end
          else if (m_s == N + 1 + TIMEOUT) begin m_active = 0; m_err = 1; end
          else m_s++;
        end else begin
          m_s++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_rv(input string nm, output logic [N*ACCW-1:0] d);
    bit ok;
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (res_valid_o) begin ok = 1'b1; d = res_data_o; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL %s: res_valid_o never rose within 120 cycles", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*ACCW-1:0] r1, r2, held;
    int err_cyc;
    bit got;
    rstn_i = 1'b1; start_i = 1'b0; res_ready_i = 1'b1;
    load_mem(1'b1, 8'h00, 8'h01);
    chk_lanes("model_ramp", calc_res(), 36);
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b0;
    @(posedge clk); #1;

    // basic op: ramp columns, x=1
    v_cnt = 0;
    pulse_start();
    wait_rv("basic", r1);
    chk_lanes("basic_res", r1, 36);
    chk("basic_valid_beats", v_cnt, 8);
    @(posedge clk); #1;

    // signed operands with backpressure and ignored starts
    load_mem(1'b0, 8'hFF, 8'hFE);
    chk_lanes("model_signed", calc_res(), 16);
    res_ready_i = 1'b0;
    pulse_start();
    wait_rv("signed", held);
    chk_lanes("signed_res", held, 16);
    for (int i = 0; i < 10; i++) begin
      start_i = (i % 2 == 0);
      @(posedge clk); #1;
      chk("hold_data", res_data_o, held);
      chk("hold_busy", busy_o, 1'b1);
    end
    start_i = 1'b0;
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("hold_done_idle", busy_o, 1'b0);

    // timeout: datapath never answers
    dp_never = 1'b1;
    pulse_start();
    got = 1'b0; err_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (err_o) begin got = 1'b1; err_cyc = cyc; break; end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL timeout: err_o never rose");
    end
    // last valid beat is the FEED cycle; DRAIN is entered at its closing
    // edge and err_o rises 64 edges later, i.e. 65 cycles after that beat
    chk("timeout_latency", err_cyc - last_v_cyc, 65);
    chk("timeout_no_res", res_valid_o, 1'b0);
    chk("timeout_idle", busy_o, 1'b0);
    dp_never = 1'b0;
    pulse_start();
    chk("err_cleared", err_o, 1'b0);
    wait_rv("after_timeout", r1);
    chk_lanes("after_timeout_res", r1, 16);
    @(posedge clk); #1;

    // reset during the 4th READ cycle
    load_mem(1'b1, 8'h00, 8'h01);
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_o && mem_addr_o == 3'd3) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL midreset: 4th read never seen");
    end
    rstn_i = 1'b1;
    @(posedge clk); #1;
    rstn_i = 1'b0;
    chk("midreset_outs", {busy_o, err_o, mem_rd_o, mm_en_o, mm_valid_o, res_valid_o}, 0);
    pulse_start();
    wait_rv("after_reset", r1);
    chk_lanes("after_reset_res", r1, 36);
    @(posedge clk); #1;

    // spurious datapath valid during READ
    pulse_start();
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    wait_rv("spurious", r1);
    chk_lanes("spurious_res", r1, 36);
    @(posedge clk); #1;

    // back-to-back with start held high
    start_i = 1'b1;
    wait_rv("b2b_first", r1);
    load_mem(1'b0, 8'hFF, 8'hFE);
    @(posedge clk); #1;
    chk("b2b_idle_gap", busy_o, 1'b0);
    wait_rv("b2b_second", r2);
    start_i = 1'b0;
    chk_lanes("b2b_first_res", r1, 36);
    chk_lanes("b2b_second_res", r2, 16);

    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
